// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline stage (main + skid) with a registered s_ready_o and synchronous flush.
// Optional macro SKID_BYPASS_EN: zero-latency combinational pass-through while the buffer is empty.
module pipe_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o
);

    // State is the pair {skid_valid, main_valid}; 2'b10 cannot occur.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             s_ready_q,    s_ready_d;
    logic [1:0]       state;

    assign state = {skid_valid_q, main_valid_q};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            s_ready_q    <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            s_ready_q    <= s_ready_d;
        end
    end

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_data_d  = '0;
            skid_data_d  = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
`ifdef SKID_BYPASS_EN
                    // A beat the consumer takes immediately never touches storage.
                    if (s_valid_i && !m_ready_i) begin
`else
                    if (s_valid_i) begin
`endif
                        main_valid_d = 1'b1;
                        main_data_d  = s_data_i;
                    end
                end
                ST_BUSY: begin
                    case ({s_valid_i, m_ready_i})
                        2'b11: main_data_d = s_data_i;
                        2'b10: begin
                            skid_valid_d = 1'b1;
                            skid_data_d  = s_data_i;
                        end
                        2'b01: main_valid_d = 1'b0;
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    // s_ready_o is low here, so s_valid_i cannot be a transfer.
                    if (m_ready_i) begin
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
        s_ready_d = ~skid_valid_d;
    end

    always_comb begin
        s_ready_o = s_ready_q;
        m_valid_o = main_valid_q;
        m_data_o  = main_data_q;
`ifdef SKID_BYPASS_EN
        if (state == ST_EMPTY) begin
            m_valid_o = s_valid_i & ~flush_i;
            m_data_o  = s_data_i;
        end
`endif
    end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: directed scenarios plus randomized traffic against a capacity-2 queue model.
// Works in both builds; SKID_BYPASS_EN selects the model's empty-buffer pass-through.
module tb_pipe_skid_buffer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [31:0] s_data_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [31:0] m_data_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];

`ifdef SKID_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 0;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 1;
`endif

    pipe_skid_buffer #(.WIDTH(32)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .flush_i   (flush_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs (called just after a falling edge), check outputs against the
    // queue model, then advance the model across the rising edge.
    task automatic step(input logic sv, input logic [31:0] sd, input logic mr, input logic fl,
                        input string tag);
        logic        exp_v;
        logic [31:0] exp_d;
        logic        exp_rdy;
        logic        bypassed;
        logic        accepted;
        s_valid_i = sv;
        s_data_i  = sd;
        m_ready_i = mr;
        flush_i   = fl;
        #1;
        exp_rdy = (q.size() < 2);
        if (q.size() > 0) begin
            exp_v = 1'b1;
            exp_d = q[0];
        end else begin
            exp_v = BYP & sv & ~fl;
            exp_d = sd;
        end
        chk({tag, "_m_valid"}, {31'b0, m_valid_o}, {31'b0, exp_v});
        if (exp_v) chk({tag, "_m_data"}, m_data_o, exp_d);
        chk({tag, "_s_ready"}, {31'b0, s_ready_o}, {31'b0, exp_rdy});
        @(posedge clk_i);
        if (fl) begin
            q.delete();
        end else begin
            bypassed = BYP && (q.size() == 0) && sv && mr;
            accepted = sv && exp_rdy;
            if (q.size() > 0 && mr) void'(q.pop_front());
            if (accepted && !bypassed) q.push_back(sd);
        end
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i   = 1'b0;
        flush_i   = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = 32'h0;
        m_ready_i = 1'b0;
        #12;
        chk("rst_m_valid", {31'b0, m_valid_o}, 32'd0);
        chk("rst_m_data",  m_data_o,           32'd0);
        chk("rst_s_ready", {31'b0, s_ready_o}, 32'd1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, "idle");

        // Streaming: three back-to-back beats with the consumer always ready.
        for (int c = 0; c < 6; c++) begin
            logic [31:0] d;
            logic        exp_v;
            d = (c < 3) ? 32'h11 * (c + 1) : 32'h0;
            s_valid_i = (c < 3);
            s_data_i  = d;
            m_ready_i = 1'b1;
            flush_i   = 1'b0;
            #1;
            exp_v = (c - LAT >= 0) && (c - LAT <= 2);
            chk("stream_valid", {31'b0, m_valid_o}, {31'b0, exp_v});
            if (exp_v) chk("stream_data", m_data_o, 32'h11 * (c - LAT + 1));
            chk("stream_ready", {31'b0, s_ready_o}, 32'd1);
            @(posedge clk_i);
            @(negedge clk_i);
            #1;
        end

        // Stall: 0xA held in main, 0xB goes to skid, then drain.
        step(1'b1, 32'hA, 1'b0, 1'b0, "stall_a");
        step(1'b1, 32'hB, 1'b0, 1'b0, "stall_b");
        chk("full_s_ready", {31'b0, s_ready_o}, 32'd0);
        chk("full_m_data",  m_data_o,           32'hA);
        step(1'b1, 32'hF0, 1'b0, 1'b0, "full_hold");
        chk("hold_m_data",  m_data_o,           32'hA);
        chk("hold_m_valid", {31'b0, m_valid_o}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, "drain_a");
        chk("drain_b_data",  m_data_o,           32'hB);
        chk("drain_s_ready", {31'b0, s_ready_o}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, "drain_b");
        chk("drained_valid", {31'b0, m_valid_o}, 32'd0);

        // Flush while full, with a beat presented in the flush cycle.
        step(1'b1, 32'hC, 1'b0, 1'b0, "fl_c");
        step(1'b1, 32'hD, 1'b0, 1'b0, "fl_d");
        step(1'b1, 32'hE, 1'b0, 1'b1, "fl_e");
        s_valid_i = 1'b0;
        s_data_i  = 32'h0;
        #1;
        chk("flush_m_valid", {31'b0, m_valid_o}, 32'd0);
        chk("flush_s_ready", {31'b0, s_ready_o}, 32'd1);
        chk("flush_m_data",  m_data_o,           32'd0);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, "post_flush");

        // Empty-buffer latency: same cycle with bypass, next cycle otherwise.
        s_valid_i = 1'b1;
        s_data_i  = 32'h55;
        m_ready_i = 1'b1;
        #1;
        chk("lat_valid_now", {31'b0, m_valid_o}, {31'b0, (LAT == 0)});
        if (LAT == 0) chk("lat_data_now", m_data_o, 32'h55);
        @(posedge clk_i);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        s_data_i  = 32'h0;
        #1;
        chk("lat_valid_next", {31'b0, m_valid_o}, {31'b0, (LAT == 1)});
        if (LAT == 1) chk("lat_data_next", m_data_o, 32'h55);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        q.delete();

        // Randomized traffic: 50% valid, 50% ready, rare flush.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) == 0), "rand");
        end

        // Asynchronous reset while full takes effect before the next edge.
        step(1'b0, 32'h0, 1'b1, 1'b1, "pre_rst_flush");
        step(1'b1, 32'h1, 1'b0, 1'b0, "pre_rst_1");
        step(1'b1, 32'h2, 1'b0, 1'b0, "pre_rst_2");
        chk("pre_rst_full", {31'b0, s_ready_o}, 32'd0);
        s_valid_i = 1'b0;
        s_data_i  = 32'h0;
        rst_n_i   = 1'b0;
        #1;
        chk("arst_m_valid", {31'b0, m_valid_o}, 32'd0);
        chk("arst_m_data",  m_data_o,           32'd0);
        chk("arst_s_ready", {31'b0, s_ready_o}, 32'd1);
        q.delete();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
